// File: rtl/axis_bad_pix_marker.sv
// Tags known-bad sensor pixels by OR-ing a flag mask into tdata, walking a
// raster-sorted bad-pixel coordinate table in step with the pixel counters.
module axis_bad_pix_marker #(
  parameter int unsigned IMG_RES_X    = 336,
  parameter int unsigned IMG_RES_Y    = 256,
  parameter int unsigned MAX_BAD_PIX  = 256,
  parameter logic [15:0] BAD_PIX_MASK = 16'h8000
) (
  input  logic                           axis_aclk,
  input  logic                           axis_areset,
  input  logic                           enable,
  input  logic                           cfg_wr_en,
  input  logic [$clog2(MAX_BAD_PIX)-1:0] cfg_wr_addr,
  input  logic [31:0]                    cfg_wr_data,
  input  logic [$clog2(MAX_BAD_PIX):0]   cfg_count,
  input  logic [15:0]                    s_axis_tdata,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic                           s_axis_tlast,
  output logic [15:0]                    m_axis_tdata,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
  output logic                           err_row_len,
  output logic                           err_unsorted,
  output logic [15:0]                    frame_marked
);

  localparam int unsigned AW = $clog2(MAX_BAD_PIX);
  localparam int unsigned XW = (IMG_RES_X > 1) ? $clog2(IMG_RES_X) : 1;
  localparam int unsigned YW = (IMG_RES_Y > 1) ? $clog2(IMG_RES_Y) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_RES_X - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_RES_Y - 1);

  logic [31:0]   tbl [MAX_BAD_PIX];

  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [AW:0]   ptr_q;
  logic [AW:0]   cnt_q;
  logic [15:0]   mcnt_q;
  logic          en_q;

  logic          s_fire_c;
  logic          frame_start_c;
  logic          en_eff_c;
  logic [AW:0]   cnt_eff_c;
  logic [AW:0]   ptr_eff_c;
  logic [15:0]   mcnt_eff_c;
  logic [31:0]   entry_c;
  logic [31:0]   pos_key_c;
  logic          active_c;
  logic          hit_c;
  logic          skip_c;
  logic [AW:0]   ptr_nxt_c;
  logic [15:0]   mcnt_nxt_c;
  logic [15:0]   data_c;
  logic          row_err_c;
  logic [XW-1:0] x_nxt_c;
  logic [YW-1:0] y_nxt_c;

  assign s_axis_tready = ~m_axis_tvalid | m_axis_tready;
  assign s_fire_c      = s_axis_tvalid & s_axis_tready;

  // Host table: no reset, combinational read at the walking pointer.
  always_ff @(posedge axis_aclk) begin
    if (cfg_wr_en) begin
      tbl[cfg_wr_addr] <= cfg_wr_data;
    end
  end

  // Frame-start beat sees freshly latched config and a rewound pointer.
  always_comb begin
    frame_start_c = (x_q == '0) && (y_q == '0);
    en_eff_c      = frame_start_c ? enable    : en_q;
    cnt_eff_c     = frame_start_c ? cfg_count : cnt_q;
    ptr_eff_c     = frame_start_c ? '0        : ptr_q;
    mcnt_eff_c    = frame_start_c ? '0        : mcnt_q;
  end

  // Entry and position compared as {y,x} keys: a smaller key is raster-before.
  always_comb begin
    entry_c    = tbl[ptr_eff_c[AW-1:0]];
    pos_key_c  = {16'(y_q), 16'(x_q)};
    active_c   = en_eff_c && (ptr_eff_c < cnt_eff_c);
    hit_c      = active_c && (entry_c == pos_key_c);
    skip_c     = active_c && (entry_c < pos_key_c);
    ptr_nxt_c  = ptr_eff_c + (AW+1)'(hit_c | skip_c);
    mcnt_nxt_c = mcnt_eff_c + 16'(hit_c);
    data_c     = hit_c ? (s_axis_tdata | BAD_PIX_MASK) : s_axis_tdata;
  end

  // Position counters resync on every tlast; x saturates on long rows.
  always_comb begin
    x_nxt_c   = x_q;
    y_nxt_c   = y_q;
    row_err_c = 1'b0;
    if (s_axis_tlast) begin
      x_nxt_c   = '0;
      y_nxt_c   = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
      row_err_c = (x_q != X_LAST);
    end else begin
      x_nxt_c   = (x_q == X_LAST) ? x_q : x_q + XW'(1);
      row_err_c = (x_q == X_LAST);
    end
  end

  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      x_q          <= '0;
      y_q          <= '0;
      ptr_q        <= '0;
      cnt_q        <= '0;
      mcnt_q       <= '0;
      en_q         <= 1'b0;
      err_row_len  <= 1'b0;
      err_unsorted <= 1'b0;
      frame_marked <= '0;
    end else if (s_fire_c) begin
      x_q    <= x_nxt_c;
      y_q    <= y_nxt_c;
      ptr_q  <= ptr_nxt_c;
      cnt_q  <= cnt_eff_c;
      mcnt_q <= mcnt_nxt_c;
      en_q   <= en_eff_c;
      if (row_err_c) begin
        err_row_len <= 1'b1;
      end
      if (skip_c) begin
        err_unsorted <= 1'b1;
      end
      if (s_axis_tlast && (y_q == Y_LAST)) begin
        frame_marked <= mcnt_nxt_c;
      end
    end
  end

  // Single output register stage.
  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (s_fire_c) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= data_c;
      m_axis_tlast  <= s_axis_tlast;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_bad_pix_marker.sv
// Scoreboard bench for axis_bad_pix_marker on an 8x4 image with hand-listed marks.
module tb_axis_bad_pix_marker;

  localparam int unsigned RX   = 8;
  localparam int unsigned RY   = 4;
  localparam int unsigned MAXB = 16;
  localparam int unsigned AW   = 4;

  logic          axis_aclk = 1'b0;
  logic          axis_areset = 1'b1;
  logic          enable = 1'b1;
  logic          cfg_wr_en = 1'b0;
  logic [AW-1:0] cfg_wr_addr = '0;
  logic [31:0]   cfg_wr_data = '0;
  logic [AW:0]   cfg_count = '0;
  logic [15:0]   s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic [15:0]   m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;
  logic          err_row_len;
  logic          err_unsorted;
  logic [15:0]   frame_marked;

  axis_bad_pix_marker #(
    .IMG_RES_X(RX), .IMG_RES_Y(RY), .MAX_BAD_PIX(MAXB), .BAD_PIX_MASK(16'h8000)
  ) dut (
    .axis_aclk(axis_aclk), .axis_areset(axis_areset), .enable(enable),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
    .cfg_count(cfg_count),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .err_row_len(err_row_len), .err_unsorted(err_unsorted),
    .frame_marked(frame_marked)
  );

  always #5 axis_aclk = ~axis_aclk;

  typedef struct packed {
    logic [15:0] d;
    logic        l;
  } beat_t;

  beat_t sb[$];
  int    checks = 0;
  int    failures = 0;
  bit    rnd_ready = 1'b0;
  bit    rnd_gap = 1'b0;
  bit    mark_map [RX*RY];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: an output handshake completes on the next rising edge.
  initial begin
    beat_t e;
    forever begin
      @(negedge axis_aclk);
      if (!axis_areset && m_axis_tvalid && m_axis_tready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out_extra: got unexpected beat %0h with empty scoreboard", m_axis_tdata);
        end else begin
          e = sb.pop_front();
          chk("out_tdata", 32'(m_axis_tdata), 32'(e.d));
          chk("out_tlast", 32'(m_axis_tlast), 32'(e.l));
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge axis_aclk);
      #1;
      m_axis_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send(input logic [15:0] d, input logic l, input bit mark, input bit chk_lat);
    beat_t e;
    int    n;
    e.d = mark ? (d | 16'h8000) : d;
    e.l = l;
    sb.push_back(e);
    if (rnd_gap) begin
      n = $urandom_range(0, 2);
      repeat (n) begin
        @(posedge axis_aclk);
        #1;
      end
    end
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    n = 0;
    do begin
      @(negedge axis_aclk);
      n++;
    end while (!s_axis_tready && n < 200);
    if (!s_axis_tready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got tready=0 after %0d cycles required 1", n);
    end
    @(posedge axis_aclk);
    #1;
    s_axis_tvalid = 1'b0;
    if (chk_lat) begin
      chk("latency_valid", 32'(m_axis_tvalid), 32'd1);
      chk("latency_data", 32'(m_axis_tdata), 32'(e.d));
    end
  endtask

  task automatic send_frame(input bit ramp, input bit lat);
    for (int i = 0; i < RX*RY; i++) begin
      send(ramp ? 16'(i) : 16'h0123, (i % RX) == RX-1, mark_map[i], lat && (i == 0));
    end
  endtask

  task automatic clear_marks();
    for (int i = 0; i < RX*RY; i++) mark_map[i] = 1'b0;
  endtask

  task automatic wr(input int a, input int x, input int y);
    cfg_wr_en   = 1'b1;
    cfg_wr_addr = AW'(a);
    cfg_wr_data = {16'(y), 16'(x)};
    @(posedge axis_aclk);
    #1;
    cfg_wr_en = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(posedge axis_aclk);
      n++;
    end
    #1;
    chk("drain_left", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    axis_areset   = 1'b1;
    s_axis_tvalid = 1'b0;
    repeat (2) @(posedge axis_aclk);
    #1;
    sb.delete();
    axis_areset = 1'b0;
  endtask

  initial begin
    int k;
    clear_marks();
    #12;
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tdata", 32'(m_axis_tdata), 32'd0);
    chk("rst_tready", 32'(s_axis_tready), 32'd1);
    chk("rst_frame_marked", 32'(frame_marked), 32'd0);
    @(posedge axis_aclk);
    #1;
    do_reset();

    // Empty table: ramp passes through untouched with one-cycle latency.
    cfg_count = '0;
    send_frame(1'b1, 1'b1);
    drain();
    chk("t1_frame_marked", 32'(frame_marked), 32'd0);
    chk("t1_err_row_len", 32'(err_row_len), 32'd0);
    chk("t1_err_unsorted", 32'(err_unsorted), 32'd0);

    // Three sorted entries: (0,0), (5,3), (7,3) -> indices 0, 29, 31.
    do_reset();
    wr(0, 0, 0); wr(1, 5, 3); wr(2, 7, 3);
    cfg_count = 5'd3;
    clear_marks();
    mark_map[0] = 1'b1; mark_map[29] = 1'b1; mark_map[31] = 1'b1;
    send_frame(1'b0, 1'b0);
    drain();
    chk("t2_frame_marked", 32'(frame_marked), 32'd3);
    chk("t2_err_unsorted", 32'(err_unsorted), 32'd0);

    // Same table under random backpressure and input gaps.
    rnd_ready = 1'b1;
    rnd_gap   = 1'b1;
    send_frame(1'b1, 1'b0);
    drain();
    rnd_ready = 1'b0;
    rnd_gap   = 1'b0;
    chk("t3_frame_marked", 32'(frame_marked), 32'd3);
    chk("t3_err_row_len", 32'(err_row_len), 32'd0);

    // Unsorted table: (2,0) marks, (1,0) is skipped at pixel (3,0).
    do_reset();
    wr(0, 2, 0); wr(1, 1, 0);
    cfg_count = 5'd2;
    clear_marks();
    mark_map[2] = 1'b1;
    send_frame(1'b1, 1'b0);
    drain();
    chk("t4_frame_marked", 32'(frame_marked), 32'd1);
    chk("t4_err_unsorted", 32'(err_unsorted), 32'd1);
    chk("t4_err_row_len", 32'(err_row_len), 32'd0);

    // Short row 1 (6 beats); entry (0,2) still marks first pixel of row 2.
    do_reset();
    wr(0, 0, 2);
    cfg_count = 5'd1;
    k = 0;
    for (int i = 0; i < RX; i++) begin send(16'(k), i == RX-1, 1'b0, 1'b0); k++; end
    for (int i = 0; i < 6; i++)  begin send(16'(k), i == 5, 1'b0, 1'b0); k++; end
    for (int r = 2; r < RY; r++) begin
      for (int i = 0; i < RX; i++) begin
        send(16'(k), i == RX-1, (r == 2) && (i == 0), 1'b0);
        k++;
      end
    end
    drain();
    chk("t5_err_row_len", 32'(err_row_len), 32'd1);
    chk("t5_err_unsorted", 32'(err_unsorted), 32'd0);
    chk("t5_frame_marked", 32'(frame_marked), 32'd1);

    // Reset at row 2 beat 3, then a full restarted frame.
    wr(0, 0, 0); wr(1, 4, 2); wr(2, 1, 3);
    cfg_count = 5'd3;
    clear_marks();
    mark_map[0] = 1'b1; mark_map[20] = 1'b1; mark_map[25] = 1'b1;
    for (int i = 0; i < 2*RX + 3; i++) begin
      send(16'(i), (i % RX) == RX-1, mark_map[i], 1'b0);
    end
    chk("t6_inflight", 32'(sb.size()), 32'd1);
    axis_areset = 1'b1;
    #1;
    chk("t6_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("t6_rst_tdata", 32'(m_axis_tdata), 32'd0);
    chk("t6_rst_tlast", 32'(m_axis_tlast), 32'd0);
    chk("t6_rst_err_row_len", 32'(err_row_len), 32'd0);
    chk("t6_rst_frame_marked", 32'(frame_marked), 32'd0);
    do_reset();
    send_frame(1'b1, 1'b0);
    drain();
    chk("t6_frame_marked", 32'(frame_marked), 32'd3);
    chk("t6_err_row_len", 32'(err_row_len), 32'd0);
    chk("t6_err_unsorted", 32'(err_unsorted), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
